pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_ctrl_stall_enc.sv | 28 ++
 rtl/pipe_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall width, stall patterns and FSM encodings for pipe_ctrl
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_t;

    // Bit 0 is PC, bit 5 is WB; a set bit holds its stage when the next one is also set.
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_IF   = 6'b000011;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;
    localparam stall_t STALL_MEM  = 6'b011111;
    localparam stall_t STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_stall_enc.sv
// rtl/pipe_ctrl_stall_enc.sv - stall_enc: combinational highest-priority stall request encoder
module stall_enc #(
    parameter int STALL_W = pipe_ctrl_pkg::STALL_W
) (
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               mask_mid,
    output logic [STALL_W-1:0] stall
);
    import pipe_ctrl_pkg::*;

    // mask_mid drops ID/EX requests from instructions that are being squashed.
    always_comb begin
        stall = STALL_W'(STALL_NONE);
        if (stallreq_mem) begin
            stall = STALL_W'(STALL_MEM);
        end else if (stallreq_ex && !mask_mid) begin
            stall = STALL_W'(STALL_EX);
        end else if (stallreq_id && !mask_mid) begin
            stall = STALL_W'(STALL_ID);
        end else if (stallreq_if) begin
            stall = STALL_W'(STALL_IF);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl #(
    parameter int STALL_W = pipe_ctrl_pkg::STALL_W,
    parameter int ADDR_W  = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               stallreq_if_in,
    input  logic               stallreq_id_in,
    input  logic               stallreq_ex_in,
    input  logic               stallreq_mem_in,
    input  logic               flush_req_in,
    input  logic [ADDR_W-1:0]  flush_target_in,
    output logic [STALL_W-1:0] stall_out,
    output logic               flush_out,
    output logic               redirect_out,
    output logic [ADDR_W-1:0]  target_out
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cycles_out,
    output logic [31:0]        flush_count_out
`endif
);
    import pipe_ctrl_pkg::*;

    state_t             state;
    logic               flush_q;
    logic               fetch_clear;
    logic [STALL_W-1:0] enc_stall;

    stall_enc #(
        .STALL_W(STALL_W)
    ) u_stall_enc (
        .stallreq_if (stallreq_if_in),
        .stallreq_id (stallreq_id_in),
        .stallreq_ex (stallreq_ex_in),
        .stallreq_mem(stallreq_mem_in),
        .mask_mid    (state == ST_FLUSH),
        .stall       (enc_stall)
    );

    always_comb begin
        stall_out = enc_stall;
        if (!rst_in || !rdy_in) begin
            stall_out = '1;
        end
    end

    // An outstanding fetch (IF or MEM stall) must land before the redirect discards it.
    assign fetch_clear  = !stallreq_mem_in && !stallreq_if_in;
    assign flush_out    = flush_q && rdy_in;
    assign redirect_out = flush_q && rdy_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= ST_IDLE;
            flush_q    <= 1'b0;
            target_out <= '0;
        end else if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    flush_q <= 1'b0;
                    if (flush_req_in) begin
                        target_out <= flush_target_in;
                        if (fetch_clear) begin
                            state   <= ST_FLUSH;
                            flush_q <= 1'b1;
                        end else begin
                            state <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (fetch_clear) begin
                        state   <= ST_FLUSH;
                        flush_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state   <= ST_IDLE;
                    flush_q <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            stall_cycles_out <= '0;
            flush_count_out  <= '0;
        end else if (rdy_in) begin
            if (enc_stall != '0) begin
                stall_cycles_out <= stall_cycles_out + 32'd1;
            end
            if (state == ST_FLUSH) begin
                flush_count_out <= flush_count_out + 32'd1;
            end
        end
    end
`endif

endmodule
